// File: rtl/cp0_regfile_param.sv
// CP0 system-control registers: MFC0 reads are combinational; MTC0/exception/ERET writes land at the next clk edge.
// Always ready, no backpressure; int_req is registered and trails its qualifying state by one cycle.
module cp0_regfile_param #(
  parameter int          COUNT_DIV  = 2,
  parameter int          NUM_HW_INT = 6,
  parameter int          TIMER_IP   = 7,
  parameter logic [31:0] PRID       = 32'h0000_4220
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ex_valid,
  input  logic [4:0]            ex_code,
  input  logic                  ex_bd,
  input  logic [31:0]           ex_pc,
  input  logic [31:0]           ex_badvaddr,
  input  logic                  eret,
  input  logic                  cp0_we,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           cp0_wdata,
  output logic [31:0]           cp0_rdata,
  input  logic [NUM_HW_INT-1:0] ext_int,
  output logic                  int_req,
  output logic [31:0]           epc,
  output logic                  status_exl
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [7:0] ADDR_PRID     = 8'h78;

  logic [7:0]  status_im;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  cause_ip_hw;
  logic [4:0]  cause_exc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [3:0]  presc;

  logic [5:0]  ext_pad;
  logic [7:0]  ti_mask;
  logic [7:0]  cause_ip;
  logic        mtc0;
  logic        wr_count;
  logic        wr_compare;
  logic        tick;
  logic        ti_set;
  logic [31:0] count_inc;
  logic [31:0] status_word;
  logic [31:0] cause_word;

  always_comb begin
    ext_pad = '0;
    ext_pad[NUM_HW_INT-1:0] = ext_int;
  end

  assign ti_mask  = {7'd0, cause_ti} << TIMER_IP;
  assign cause_ip = {cause_ip_hw, cause_ip_sw} | ti_mask;

  // MTC0 is discarded whenever an exception or ERET commits in the same cycle.
  assign mtc0       = cp0_we & ~ex_valid & ~eret;
  assign wr_count   = mtc0 && (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0 && (cp0_addr == ADDR_COMPARE);
  assign tick       = (presc == 4'(COUNT_DIV - 1));
  assign count_inc  = count + 32'd1;
  assign ti_set     = wr_count ? (cp0_wdata == compare) : (tick && (count_inc == compare));

  assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_word  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = status_word;
      ADDR_CAUSE:    cp0_rdata = cause_word;
      ADDR_EPC:      cp0_rdata = epc;
      ADDR_PRID:     cp0_rdata = PRID;
      default:       cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_im   <= 8'd0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ti    <= 1'b0;
      cause_ip_sw <= 2'd0;
      cause_ip_hw <= 6'd0;
      cause_exc   <= 5'd0;
      epc         <= 32'd0;
      badvaddr    <= 32'd0;
      count       <= 32'd0;
      compare     <= 32'hFFFF_FFFF;
      presc       <= 4'd0;
      int_req     <= 1'b0;
    end else begin
      cause_ip_hw <= ext_pad;
      int_req     <= status_ie & ~status_exl & (|(cause_ip & status_im));

      if (wr_count) begin
        count <= cp0_wdata;
        presc <= 4'd0;
      end else if (tick) begin
        count <= count_inc;
        presc <= 4'd0;
      end else begin
        presc <= presc + 4'd1;
      end

      // Clearing via a Compare write beats a coincident match.
      if (wr_compare) begin
        compare  <= cp0_wdata;
        cause_ti <= 1'b0;
      end else if (ti_set) begin
        cause_ti <= 1'b1;
      end

      if (ex_valid) begin
        status_exl <= 1'b1;
        cause_exc  <= ex_code;
        if (!status_exl) begin
          cause_bd <= ex_bd;
          epc      <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
        end
        if ((ex_code == 5'd4) || (ex_code == 5'd5))
          badvaddr <= ex_badvaddr;
      end else if (eret) begin
        status_exl <= 1'b0;
      end else if (cp0_we) begin
        case (cp0_addr)
          ADDR_STATUS: begin
            status_im  <= cp0_wdata[15:8];
            status_exl <= cp0_wdata[1];
            status_ie  <= cp0_wdata[0];
          end
          ADDR_CAUSE: cause_ip_sw <= cp0_wdata[9:8];
          ADDR_EPC:   epc         <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_regfile_param.sv
// Bench for cp0_regfile_param: reset table, directed corner sequences, then random traffic vs a reference model.
module tb_cp0_regfile_param;

  localparam int CDIV = 2;
  localparam int TIP  = 7;

  localparam logic [7:0] A_BAD  = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_STAT = 8'h60;
  localparam logic [7:0] A_CAUS = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;
  localparam logic [7:0] A_PRID = 8'h78;

  logic        clk = 1'b0;
  logic        resetn, ex_valid, ex_bd, eret, cp0_we;
  logic [4:0]  ex_code;
  logic [31:0] ex_pc, ex_badvaddr, cp0_wdata, cp0_rdata, epc;
  logic [7:0]  cp0_addr;
  logic [5:0]  ext_int;
  logic        int_req, status_exl;

  int nvec = 0;
  int nmis = 0;

  cp0_regfile_param #(.COUNT_DIV(CDIV), .NUM_HW_INT(6), .TIMER_IP(TIP), .PRID(32'h0000_4220)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_code(ex_code), .ex_bd(ex_bd),
    .ex_pc(ex_pc), .ex_badvaddr(ex_badvaddr), .eret(eret), .cp0_we(cp0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .ext_int(ext_int),
    .int_req(int_req), .epc(epc), .status_exl(status_exl)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rst_tab[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
    step();
    cp0_we = 1'b0;
  endtask

  task automatic rd(input string n, input logic [7:0] a, input logic [31:0] mask, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(n, cp0_rdata & mask, exp);
  endtask

  task automatic raise_ex(input logic [4:0] code, input logic bd, input logic [31:0] pc, input logic [31:0] bad);
    ex_valid = 1'b1; ex_code = code; ex_bd = bd; ex_pc = pc; ex_badvaddr = bad;
    step();
    ex_valid = 1'b0;
  endtask

  // Reference model: Count is derived from the value last loaded plus elapsed cycles.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti, m_ireq;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_cmp, m_base;
  int          m_cyc;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / CDIV);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = {m_hw, m_ipsw};
    if (m_ti) ip[TIP] = 1'b1;
    return ip;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_BAD:   return m_bad;
      A_CNT:   return m_count();
      A_CMP:   return m_cmp;
      A_STAT:  return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
      A_CAUS:  return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
      A_EPC:   return m_epc;
      A_PRID:  return 32'h0000_4220;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0; m_ireq = 1'b0;
    m_ipsw = 2'd0; m_hw = 6'd0; m_code = 5'd0; m_epc = 32'd0; m_bad = 32'd0;
    m_cmp = 32'hFFFF_FFFF; m_base = 32'd0; m_cyc = 0;
  endtask

  task automatic m_step();
    logic        wr_ok, ld, nireq;
    logic [31:0] oldc, newc;
    if (!resetn) begin
      m_reset();
      return;
    end
    nireq = m_ie & ~m_exl & (|(m_ip() & m_im));
    wr_ok = cp0_we & ~ex_valid & ~eret;
    ld    = wr_ok && (cp0_addr == A_CNT);
    oldc  = m_count();
    if (ld) begin
      m_base = cp0_wdata;
      m_cyc  = 0;
    end else begin
      m_cyc++;
    end
    newc = m_count();
    if (wr_ok && cp0_addr == A_CMP) m_ti = 1'b0;
    else if (ld ? (cp0_wdata == m_cmp) : (newc != oldc && newc == m_cmp)) m_ti = 1'b1;
    if (wr_ok && cp0_addr == A_CMP) m_cmp = cp0_wdata;
    m_hw = ext_int;
    if (ex_valid) begin
      if (!m_exl) begin
        m_bd  = ex_bd;
        m_epc = ex_bd ? ex_pc - 32'd4 : ex_pc;
      end
      m_exl  = 1'b1;
      m_code = ex_code;
      if (ex_code == 5'd4 || ex_code == 5'd5) m_bad = ex_badvaddr;
    end else if (eret) begin
      m_exl = 1'b0;
    end else if (wr_ok && cp0_addr == A_STAT) begin
      m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
    end else if (wr_ok && cp0_addr == A_CAUS) begin
      m_ipsw = cp0_wdata[9:8];
    end
    m_ireq = nireq;
  endtask

  initial begin
    resetn = 1'b0; ex_valid = 1'b0; ex_bd = 1'b0; eret = 1'b0; cp0_we = 1'b0;
    ex_code = 5'd0; ex_pc = 32'd0; ex_badvaddr = 32'd0; cp0_wdata = 32'd0;
    cp0_addr = 8'd0; ext_int = 6'd0;

    rst_tab[0] = '{"rst_badvaddr", A_BAD,  32'h0000_0000};
    rst_tab[1] = '{"rst_count",    A_CNT,  32'h0000_0000};
    rst_tab[2] = '{"rst_compare",  A_CMP,  32'hFFFF_FFFF};
    rst_tab[3] = '{"rst_status",   A_STAT, 32'h0040_0000};
    rst_tab[4] = '{"rst_cause",    A_CAUS, 32'h0000_0000};
    rst_tab[5] = '{"rst_epc",      A_EPC,  32'h0000_0000};
    rst_tab[6] = '{"rst_prid",     A_PRID, 32'h0000_4220};
    rst_tab[7] = '{"rst_unmapped", 8'h01,  32'h0000_0000};
    rst_tab[8] = '{"rst_unmapped2",8'hFF,  32'h0000_0000};

    // Reset state
    step();
    resetn = 1'b1;
    foreach (rst_tab[i]) rd(rst_tab[i].name, rst_tab[i].addr, 32'hFFFF_FFFF, rst_tab[i].exp);
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_exl", 32'(status_exl), 32'd0);

    // Exception entry, nested exception, ERET
    raise_ex(5'd4, 1'b1, 32'hBFC0_0104, 32'h0000_0013);
    chk("ex1_epc", epc, 32'hBFC0_0100);
    chk("ex1_exl", 32'(status_exl), 32'd1);
    rd("ex1_cause", A_CAUS, 32'hFFFF_FFFF, 32'h8000_0010);
    rd("ex1_badvaddr", A_BAD, 32'hFFFF_FFFF, 32'h0000_0013);
    rd("ex1_status", A_STAT, 32'hFFFF_FFFF, 32'h0040_0002);
    raise_ex(5'd5, 1'b0, 32'h8000_0000, 32'h0000_0044);
    chk("ex2_epc_kept", epc, 32'hBFC0_0100);
    rd("ex2_cause", A_CAUS, 32'hFFFF_FFFF, 32'h8000_0014);
    rd("ex2_badvaddr", A_BAD, 32'hFFFF_FFFF, 32'h0000_0044);
    raise_ex(5'd8, 1'b0, 32'h8000_0010, 32'h0000_0099);
    rd("ex3_cause", A_CAUS, 32'hFFFF_FFFF, 32'h8000_0020);
    rd("ex3_badvaddr_kept", A_BAD, 32'hFFFF_FFFF, 32'h0000_0044);
    eret = 1'b1; step(); eret = 1'b0;
    chk("eret_exl", 32'(status_exl), 32'd0);

    // Timer: Count=0, Compare=5 matches after 10 cycles at COUNT_DIV=2
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'd0);
    repeat (9) step();
    rd("ti_count9", A_CNT, 32'hFFFF_FFFF, 32'd4);
    rd("ti_before", A_CAUS, 32'h4000_8000, 32'h0);
    step();
    rd("ti_count10", A_CNT, 32'hFFFF_FFFF, 32'd5);
    rd("ti_set", A_CAUS, 32'h4000_8000, 32'h4000_8000);
    wr(A_CMP, 32'd7);
    rd("ti_clr", A_CAUS, 32'h4000_8000, 32'h0);
    step(); step();
    wr(A_CMP, 32'd7);
    rd("ti_clr_prio_count", A_CNT, 32'hFFFF_FFFF, 32'd7);
    rd("ti_clr_prio", A_CAUS, 32'h4000_8000, 32'h0);
    wr(A_CNT, 32'd7);
    rd("ti_load_eq", A_CAUS, 32'h4000_8000, 32'h4000_8000);
    wr(A_CMP, 32'hFFFF_FFFF);

    // Timer interrupt through int_req, masked by EXL
    wr(A_STAT, 32'h0000_8001);
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'd3);
    chk("irq_lat0", 32'(int_req), 32'd0);
    step();
    chk("irq_lat1", 32'(int_req), 32'd1);
    raise_ex(5'd0, 1'b0, 32'h8000_1000, 32'd0);
    chk("irq_ex_same", 32'(int_req), 32'd1);
    step();
    chk("irq_ex_next", 32'(int_req), 32'd0);
    chk("irq_ex_epc", epc, 32'h8000_1000);
    eret = 1'b1; step(); eret = 1'b0;
    chk("irq_eret_same", 32'(int_req), 32'd0);
    step();
    chk("irq_eret_next", 32'(int_req), 32'd1);
    wr(A_CMP, 32'hFFFF_FFFF);
    step();
    chk("irq_ti_cleared", 32'(int_req), 32'd0);
    wr(A_STAT, 32'd0);

    // External interrupt line 1 -> IP3
    wr(A_STAT, 32'h0000_0801);
    ext_int = 6'b000010;
    step();
    rd("ext_ip3", A_CAUS, 32'h0000_FF00, 32'h0000_0800);
    chk("ext_irq_1", 32'(int_req), 32'd0);
    step();
    chk("ext_irq_2", 32'(int_req), 32'd1);
    ext_int = 6'd0;
    step();
    rd("ext_ip3_off", A_CAUS, 32'h0000_FF00, 32'h0);
    step();
    chk("ext_irq_off", 32'(int_req), 32'd0);
    wr(A_STAT, 32'd0);

    // Dropped MTC0 under ERET/exception, Cause write mask, read-only addresses
    raise_ex(5'd0, 1'b0, 32'h8000_2000, 32'd0);
    eret = 1'b1; cp0_we = 1'b1; cp0_addr = A_STAT; cp0_wdata = 32'h0000_FF03;
    step();
    eret = 1'b0; cp0_we = 1'b0;
    rd("eret_drop_status", A_STAT, 32'hFFFF_FFFF, 32'h0040_0000);
    chk("eret_drop_exl", 32'(status_exl), 32'd0);
    ex_valid = 1'b1; ex_code = 5'd0; cp0_we = 1'b1; cp0_addr = A_STAT; cp0_wdata = 32'h0000_FF01;
    step();
    ex_valid = 1'b0; cp0_we = 1'b0;
    rd("ex_drop_status", A_STAT, 32'hFFFF_FFFF, 32'h0040_0002);
    eret = 1'b1; step(); eret = 1'b0;
    wr(A_CAUS, 32'hFFFF_FFFF);
    rd("cause_wmask", A_CAUS, 32'h4000_FF00, 32'h0000_0300);
    wr(A_CAUS, 32'd0);
    rd("cause_wclr", A_CAUS, 32'h0000_FF00, 32'h0);
    wr(8'h01, 32'hFFFF_FFFF);
    rd("unmapped_wr", 8'h01, 32'hFFFF_FFFF, 32'h0);
    wr(A_PRID, 32'd0);
    rd("prid_ro", A_PRID, 32'hFFFF_FFFF, 32'h0000_4220);

    // Reset wins over a coincident exception and MTC0
    resetn = 1'b0; ex_valid = 1'b1; ex_code = 5'd4; ex_badvaddr = 32'h55;
    cp0_we = 1'b1; cp0_addr = A_CMP; cp0_wdata = 32'd5;
    step();
    resetn = 1'b1; ex_valid = 1'b0; cp0_we = 1'b0;
    chk("rstmid_epc", epc, 32'd0);
    chk("rstmid_exl", 32'(status_exl), 32'd0);
    rd("rstmid_compare", A_CMP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("rstmid_badvaddr", A_BAD, 32'hFFFF_FFFF, 32'h0);
    rd("rstmid_cause", A_CAUS, 32'hFFFF_FFFF, 32'h0);

    // Randomised traffic against the reference model
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      resetn   = ($urandom_range(0, 199) != 0);
      ex_valid = ($urandom_range(0, 11) == 0);
      ex_bd    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ex_code = 5'd4;
        1: ex_code = 5'd5;
        default: ex_code = 5'($urandom);
      endcase
      ex_pc       = $urandom;
      ex_badvaddr = $urandom;
      eret        = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0: cp0_addr = A_BAD;
        1, 9: cp0_addr = A_CNT;
        2, 8: cp0_addr = A_CMP;
        3: cp0_addr = A_STAT;
        4: cp0_addr = A_CAUS;
        5: cp0_addr = A_EPC;
        6: cp0_addr = A_PRID;
        default: cp0_addr = 8'($urandom);
      endcase
      cp0_we = ($urandom_range(0, 2) == 0) && (cp0_addr != A_BAD) && (cp0_addr != A_EPC);
      if (cp0_addr == A_CMP)      cp0_wdata = m_count() + 32'($urandom_range(0, 12));
      else if (cp0_addr == A_CNT) cp0_wdata = m_cmp - 32'($urandom_range(0, 6));
      else                        cp0_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
      #1;
      chk("rnd_rdata", cp0_rdata, m_read(cp0_addr));
      chk("rnd_int_req", 32'(int_req), 32'(m_ireq));
      chk("rnd_epc", epc, m_epc);
      chk("rnd_exl", 32'(status_exl), 32'(m_exl));
      @(posedge clk);
      m_step();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
